// File: rtl/alu_compare_block_if.sv
// Operand/function and registered-result bundle for alu_compare_block.
interface alu_compare_block_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       alufn;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             z;
   logic             v;
   logic             n;
   logic             cmp;

   modport master (
      output in_valid, a, b, alufn,
      input  out_valid, result, cout, z, v, n, cmp
   );

   modport slave (
      input  in_valid, a, b, alufn,
      output out_valid, result, cout, z, v, n, cmp
   );
endinterface

// File: rtl/alu_compare_block.sv
// Registered add/sub with 4-bit lookahead groups, Z/V/N flags and signed compare.
// Optional CMP_ULT_EN: alufn[2:1]=00 selects unsigned less-than (~cout).
module alu_compare_block #(
   parameter int unsigned WIDTH = 16
) (
   input logic              clk,
   input logic              rst,
   alu_compare_block_if.slave bus
);
   localparam int unsigned NG = WIDTH / 4;

   logic [WIDTH-1:0] w_bx;
   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_c;
   logic [WIDTH-1:0] w_s;
   logic [NG:0]      w_gc;
   logic             w_cout;
   logic             w_z;
   logic             w_v;
   logic             w_n;
   logic             w_cmp;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_z;
   logic             r_v;
   logic             r_n;
   logic             r_cmp;

   assign w_bx    = bus.b ^ {WIDTH{bus.alufn[0]}};
   assign w_g     = bus.a & w_bx;
   assign w_p     = bus.a ^ w_bx;
   assign w_gc[0] = bus.alufn[0];

   // Each group expands its internal carries from the group carry-in only.
   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      localparam int unsigned B = 4 * gi;
      logic w_grp_g;
      logic w_grp_p;

      assign w_c[B]   = w_gc[gi];
      assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[gi]);
      assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                      | (w_p[B+1] & w_p[B] & w_gc[gi]);
      assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                      | (w_p[B+2] & w_p[B+1] & w_g[B])
                      | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[gi]);

      assign w_grp_g = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                     | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                     | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
      assign w_grp_p = &w_p[B+3:B];

      assign w_gc[gi+1] = w_grp_g | (w_grp_p & w_gc[gi]);
   end

   assign w_s    = w_p ^ w_c;
   assign w_cout = w_gc[NG];
   assign w_z    = ~|w_s;
   assign w_n    = w_s[WIDTH-1];
   assign w_v    = (bus.a[WIDTH-1] & w_bx[WIDTH-1] & ~w_s[WIDTH-1])
                 | (~bus.a[WIDTH-1] & ~w_bx[WIDTH-1] & w_s[WIDTH-1]);

   always_comb begin
      w_cmp = 1'b0;
      unique case (bus.alufn[2:1])
         2'b01:   w_cmp = w_z;
         2'b10:   w_cmp = w_n ^ w_v;
         2'b11:   w_cmp = w_z | (w_n ^ w_v);
`ifdef CMP_ULT_EN
         default: w_cmp = ~w_cout;
`else
         default: w_cmp = 1'b0;
`endif
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_cout      <= 1'b0;
         r_z         <= 1'b0;
         r_v         <= 1'b0;
         r_n         <= 1'b0;
         r_cmp       <= 1'b0;
      end else begin
         r_out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_result <= w_s;
            r_cout   <= w_cout;
            r_z      <= w_z;
            r_v      <= w_v;
            r_n      <= w_n;
            r_cmp    <= w_cmp;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.cout      = r_cout;
   assign bus.z         = r_z;
   assign bus.v         = r_v;
   assign bus.n         = r_n;
   assign bus.cmp       = r_cmp;
endmodule

// File: tb/tb_alu_compare_block.sv
// Directed bench for alu_compare_block with hand-computed expected flags/results.
module tb_alu_compare_block;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;

   alu_compare_block_if #(.WIDTH(16)) bus_if ();

   alu_compare_block #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

`ifdef CMP_ULT_EN
   localparam logic EXP_ULT = 1'b1;
`else
   localparam logic EXP_ULT = 1'b0;
`endif

   task automatic drive(input logic r, input logic vld, input logic [15:0] va,
                        input logic [15:0] vb, input logic [2:0] fn);
      @(negedge clk);
      rst             = r;
      bus_if.in_valid = vld;
      bus_if.a        = va;
      bus_if.b        = vb;
      bus_if.alufn    = fn;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input string fld, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [15:0] er, input logic ec,
                            input logic ez, input logic ev, input logic en,
                            input logic ecmp, input logic eov);
      chk(tag, "result",    bus_if.result,          er);
      chk(tag, "cout",      {15'd0, bus_if.cout},   {15'd0, ec});
      chk(tag, "z",         {15'd0, bus_if.z},      {15'd0, ez});
      chk(tag, "v",         {15'd0, bus_if.v},      {15'd0, ev});
      chk(tag, "n",         {15'd0, bus_if.n},      {15'd0, en});
      chk(tag, "cmp",       {15'd0, bus_if.cmp},    {15'd0, ecmp});
      chk(tag, "out_valid", {15'd0, bus_if.out_valid}, {15'd0, eov});
   endtask

   initial begin
      rst             = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.a        = 16'h1234;
      bus_if.b        = 16'h0001;
      bus_if.alufn    = 3'b000;

      // reset wins over in_valid
      drive(1'b1, 1'b1, 16'hFFFF, 16'h0001, 3'b000);
      check_all("reset",       16'h0000, 0, 0, 0, 0, 0, 0);

      // back-to-back ops, one per cycle
      drive(1'b0, 1'b1, 16'h0101, 16'h0011, 3'b101);
      check_all("sub_lt_pos",  16'h00F0, 1, 0, 0, 0, 0, 1);
      drive(1'b0, 1'b1, 16'hC0FF, 16'hEECC, 3'b101);
      check_all("sub_lt_neg",  16'hD233, 0, 0, 0, 1, 1, 1);
      drive(1'b0, 1'b1, 16'hA234, 16'h8000, 3'b101);
      check_all("sub_lt_a234", 16'h2234, 1, 0, 0, 0, 0, 1);
      drive(1'b0, 1'b1, 16'hFFFF, 16'h0001, 3'b101);
      check_all("sub_lt_m1",   16'hFFFE, 1, 0, 0, 1, 1, 1);
      drive(1'b0, 1'b1, 16'h8000, 16'h0001, 3'b101);
      check_all("sub_lt_ovf",  16'h7FFF, 1, 0, 1, 0, 1, 1);
      drive(1'b0, 1'b1, 16'h1234, 16'h1234, 3'b011);
      check_all("sub_eq",      16'h0000, 1, 1, 0, 0, 1, 1);
      drive(1'b0, 1'b1, 16'h1234, 16'h1234, 3'b111);
      check_all("sub_le_eq",   16'h0000, 1, 1, 0, 0, 1, 1);
      drive(1'b0, 1'b1, 16'h0005, 16'h0003, 3'b111);
      check_all("sub_le_gt",   16'h0002, 1, 0, 0, 0, 0, 1);
      drive(1'b0, 1'b1, 16'hFFFF, 16'h0001, 3'b000);
      check_all("add_wrap",    16'h0000, 1, 1, 0, 0, 0, 1);
      drive(1'b0, 1'b1, 16'h7FFF, 16'h0001, 3'b000);
      check_all("add_ovf",     16'h8000, 0, 0, 1, 1, 0, 1);
      drive(1'b0, 1'b1, 16'h0001, 16'hFFFE, 3'b100);
      check_all("add_lt_flag", 16'hFFFF, 0, 0, 0, 1, 1, 1);
      drive(1'b0, 1'b1, 16'h1234, 16'h4321, 3'b000);
      check_all("add_plain",   16'h5555, 0, 0, 0, 0, 0, 1);
      drive(1'b0, 1'b1, 16'h0001, 16'hFFFF, 3'b001);
      check_all("sub_ult",     16'h0002, 0, 0, 0, 0, EXP_ULT, 1);

      // idle cycle holds data, drops valid
      drive(1'b0, 1'b0, 16'hAAAA, 16'h5555, 3'b101);
      check_all("hold",        16'h0002, 0, 0, 0, 0, EXP_ULT, 0);

      drive(1'b0, 1'b1, 16'h7FFF, 16'h0001, 3'b000);
      check_all("pre_reset",   16'h8000, 0, 0, 1, 1, 0, 1);
      drive(1'b1, 1'b1, 16'hFFFF, 16'h0001, 3'b000);
      check_all("mid_reset",   16'h0000, 0, 0, 0, 0, 0, 0);
      drive(1'b0, 1'b1, 16'hABCD, 16'h1111, 3'b000);
      check_all("post_reset",  16'hBCDE, 0, 0, 0, 1, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
